// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access unit.
//   state_e      : access FSM states
//   SZ_*         : MemSizeM encodings (3 is reserved and behaves as a word)
//   misaligned   : alignment check for an access size and byte offset
//   byte_enables : lane enables for an access size and byte offset
//   store_lanes  : store data replicated across the lanes the size covers
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    WAIT_RSP = 2'd2,
    DONE     = 2'd3
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = off[0];
      default: misaligned = (off != 2'd0);
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: byte_enables = 4'b0001 << off;
      SZ_HALF: byte_enables = 4'b0011 << off;
      default: byte_enables = 4'b1111;
    endcase
  endfunction

  // The responder picks the lane(s) with the byte enables, so replicating
  // the low bits lets it ignore the offset entirely.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: store_lanes = {4{data[7:0]}};
      SZ_HALF: store_lanes = {2{data[15:0]}};
      default: store_lanes = data;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load alignment: picks the addressed byte/half out of the read word and
// sign- or zero-extends it to 32 bits. Purely combinational.
//   rdata  : read word from the responder
//   offset : byte offset (address bits [1:0]) of the access
//   size   : SZ_BYTE / SZ_HALF / word
//   zext   : zero-extend instead of sign-extend
//   data   : extended load result
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        zext,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = rdata[{offset, 3'b000} +: 8];
    // Halves are always 2-byte aligned here, so only offset[1] matters.
    lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: data = zext ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: data = zext ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the data-memory interface. Turns a MEM-stage load/store
// into a valid/ready request, stalls the pipeline while it is outstanding and
// returns the aligned, extended load result in DONE.
//   clk, rst_n            : clock, synchronous active-low reset
//   MemReadM/MemWriteM    : load/store in MEM (both set is handled as store)
//   MemSizeM/MemUnsignedM : access size, zero-extend for loads
//   ALUOutM/WriteDataM    : byte address, store data
//   StallM                : freeze IF..MEM while the access is in flight
//   LoadDataM             : load result, non-zero only in DONE
//   AlignErrM             : misaligned access rejected (no request issued)
//   BusErrM               : responder timed out, reported in DONE
//   dmem_req_*            : request channel (valid/ready, we, addr, be, wdata)
//   dmem_rsp_valid/rdata  : response channel
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_W  = 30,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [1:0]        MemSizeM,
  input  logic              MemUnsignedM,
  input  logic [31:0]       ALUOutM,
  input  logic [31:0]       WriteDataM,
  output logic              StallM,
  output logic [31:0]       LoadDataM,
  output logic              AlignErrM,
  output logic              BusErrM,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_rsp_valid,
  input  logic [31:0]       dmem_rdata
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [31:0]      rdata_q;
  logic [3:0]       be_q;
  logic [1:0]       size_q;
  logic             we_q;
  logic             zext_q;
  logic             timeout_q;

  logic             pending;
  logic             misal;
  logic [31:0]      aligned;

  assign pending = MemReadM | MemWriteM;
  assign misal   = misaligned(MemSizeM, ALUOutM[1:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      be_q      <= '0;
      size_q    <= '0;
      we_q      <= 1'b0;
      zext_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pending && !misal) begin
            addr_q    <= ALUOutM;
            we_q      <= MemWriteM;
            size_q    <= MemSizeM;
            zext_q    <= MemUnsignedM;
            be_q      <= byte_enables(MemSizeM, ALUOutM[1:0]);
            wdata_q   <= store_lanes(MemSizeM, WriteDataM);
            rdata_q   <= '0;
            timeout_q <= 1'b0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            cnt   <= '0;
            state <= WAIT_RSP;
          end
        end
        WAIT_RSP: begin
          // A response arriving on the last counted cycle still wins over the timeout.
          if (dmem_rsp_valid) begin
            if (!we_q) rdata_q <= dmem_rdata;
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            timeout_q <= 1'b1;
            rdata_q   <= '0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // The pipeline moves on this edge, so the same access is never re-issued.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  load_align u_load_align (
    .rdata  (rdata_q),
    .offset (addr_q[1:0]),
    .size   (size_q),
    .zext   (zext_q),
    .data   (aligned)
  );

  assign StallM         = ((state == IDLE) && pending && !misal) ||
                          (state == REQ) || (state == WAIT_RSP);
  assign AlignErrM      = (state == IDLE) && pending && misal;
  assign BusErrM        = (state == DONE) && timeout_q;
  assign LoadDataM      = ((state == DONE) && !timeout_q) ? aligned : 32'd0;
  assign dmem_req_valid = (state == REQ);
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q[ADDR_W+1:2];
  assign dmem_be        = be_q;
  assign dmem_wdata     = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: a responder driven from tasks, with a request
// queue and a load-result queue filled when an access is launched and drained
// when the request handshake and the DONE cycle are observed.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        MemReadM;
  logic        MemWriteM;
  logic [1:0]  MemSizeM;
  logic        MemUnsignedM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic        StallM;
  logic [31:0] LoadDataM;
  logic        AlignErrM;
  logic        BusErrM;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_we;
  logic [29:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
  } req_t;

  typedef struct {
    logic [31:0] data;
    logic        buserr;
    int          stall;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit #(.ADDR_W(30), .TIMEOUT(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .MemReadM       (MemReadM),
    .MemWriteM      (MemWriteM),
    .MemSizeM       (MemSizeM),
    .MemUnsignedM   (MemUnsignedM),
    .ALUOutM        (ALUOutM),
    .WriteDataM     (WriteDataM),
    .StallM         (StallM),
    .LoadDataM      (LoadDataM),
    .AlignErrM      (AlignErrM),
    .BusErrM        (BusErrM),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_we        (dmem_we),
    .dmem_addr      (dmem_addr),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rdata     (dmem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    MemReadM     = 1'b0;
    MemWriteM    = 1'b0;
    MemSizeM     = 2'd0;
    MemUnsignedM = 1'b0;
    ALUOutM      = 32'd0;
    WriteDataM   = 32'd0;
  endtask

  // One complete access. ready_dly = REQ cycles with ready low before it is
  // raised; rsp_dly = WAIT_RSP cycles before the response (-1: never answer).
  task automatic do_access(input string name, input logic rd, input logic wr,
                           input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int ready_dly, input int rsp_dly,
                           input logic [31:0] rdata,
                           input logic [29:0] exp_addr, input logic [3:0] exp_be,
                           input logic [31:0] exp_wdata, input logic [31:0] exp_load,
                           input logic exp_buserr);
    req_t        r;
    rsp_t        s;
    int          phase;
    int          waited;
    int          rcnt;
    int          stall_cnt;
    bit          seen;
    bit          done;
    logic [29:0] a0;
    logic [3:0]  be0;
    logic [31:0] w0;
    @(negedge clk);
    MemReadM     = rd;
    MemWriteM    = wr;
    MemSizeM     = size;
    MemUnsignedM = uns;
    ALUOutM      = addr;
    WriteDataM   = wd;
    req_q.push_back('{addr: exp_addr, be: exp_be, wdata: exp_wdata, we: wr});
    rsp_q.push_back('{data: exp_load, buserr: exp_buserr,
                      stall: 2 + ready_dly + ((rsp_dly >= 0) ? rsp_dly + 1 : 8)});
    phase = 0; waited = 0; rcnt = 0; stall_cnt = 0; seen = 0; done = 0;
    a0 = '0; be0 = '0; w0 = '0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      if (cyc > 0) @(negedge clk);
      #1;
      if (StallM) stall_cnt++;
      if (phase == 0) begin
        if (dmem_req_valid) begin
          if (!seen) begin
            a0 = dmem_addr; be0 = dmem_be; w0 = dmem_wdata; seen = 1;
          end else begin
            n_tests++;
            if (dmem_addr !== a0 || dmem_be !== be0 || dmem_wdata !== w0) begin
              n_fail++;
              $display("FAIL %s req_stable: got addr=%h be=%b wdata=%h, required addr=%h be=%b wdata=%h",
                       name, dmem_addr, dmem_be, dmem_wdata, a0, be0, w0);
            end
          end
          if (waited >= ready_dly) begin
            dmem_req_ready = 1'b1;
            r = req_q.pop_front();
            n_tests++;
            if (dmem_addr !== r.addr || dmem_be !== r.be || dmem_we !== r.we ||
                (r.we && dmem_wdata !== r.wdata)) begin
              n_fail++;
              $display("FAIL %s req: got addr=%h be=%b we=%b wdata=%h, required addr=%h be=%b we=%b wdata=%h",
                       name, dmem_addr, dmem_be, dmem_we, dmem_wdata, r.addr, r.be, r.we, r.wdata);
            end
            phase = 1;
          end else begin
            dmem_req_ready = 1'b0;
            waited++;
          end
        end else if (seen) begin
          n_tests++; n_fail++;
          $display("FAIL %s req_withdrawn: got valid=0, required valid=1", name);
          done = 1;
        end else if (!StallM) begin
          n_tests++; n_fail++;
          $display("FAIL %s no_request: got StallM=0 before any request, required a request", name);
          done = 1;
        end
      end else begin
        dmem_req_ready = 1'b0;
        if (StallM) begin
          if (rsp_dly >= 0 && rcnt == rsp_dly) begin
            dmem_rsp_valid = 1'b1;
            dmem_rdata     = rdata;
          end else begin
            dmem_rsp_valid = 1'b0;
            dmem_rdata     = 32'h5A5A_5A5A;
          end
          rcnt++;
        end else begin
          // DONE: check the result, then let the pipeline move on.
          dmem_rsp_valid = 1'b0;
          s = rsp_q.pop_front();
          if (rd && !wr) begin
            n_tests++;
            if (LoadDataM !== s.data) begin
              n_fail++;
              $display("FAIL %s load_data: got %h, required %h", name, LoadDataM, s.data);
            end
          end
          n_tests++;
          if (BusErrM !== s.buserr) begin
            n_fail++;
            $display("FAIL %s bus_err: got %b, required %b", name, BusErrM, s.buserr);
          end
          n_tests++;
          if (stall_cnt != s.stall) begin
            n_fail++;
            $display("FAIL %s stall_cycles: got %0d, required %0d", name, stall_cnt, s.stall);
          end
          n_tests++;
          if (dmem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s valid_in_done: got %b, required 0", name, dmem_req_valid);
          end
          clear_inputs();
          done = 1;
        end
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL %s completion: got no DONE within 200 cycles, required DONE", name);
      clear_inputs();
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (StallM !== 1'b0 || BusErrM !== 1'b0 || LoadDataM !== 32'd0) begin
      n_fail++;
      $display("FAIL %s back_to_idle: got stall=%b buserr=%b load=%h, required 0/0/0",
               name, StallM, BusErrM, LoadDataM);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b0;
    dmem_rdata     = 32'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (StallM !== 1'b0 || dmem_req_valid !== 1'b0 || AlignErrM !== 1'b0 || BusErrM !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got stall=%b valid=%b align=%b bus=%b, required all 0",
               StallM, dmem_req_valid, AlignErrM, BusErrM);
    end
    n_tests++;
    if (LoadDataM !== 32'd0 || dmem_addr !== 30'd0 || dmem_be !== 4'd0 ||
        dmem_wdata !== 32'd0 || dmem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_data: got load=%h addr=%h be=%b wdata=%h we=%b, required all 0",
               LoadDataM, dmem_addr, dmem_be, dmem_wdata, dmem_we);
    end
  endtask

  task automatic test_store_word();
    do_access("sw", 1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, 2, 32'd0,
              30'h4, 4'b1111, 32'hDEAD_BEEF, 32'd0, 1'b0);
  endtask

  task automatic test_byte();
    do_access("lb", 1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'd0, 0, 0, 32'h80FF_7F01,
              30'h4, 4'b1000, 32'd0, 32'hFFFF_FF80, 1'b0);
    do_access("lbu", 1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'd0, 0, 0, 32'h80FF_7F01,
              30'h4, 4'b1000, 32'd0, 32'h0000_0080, 1'b0);
    do_access("lb_lane1", 1'b1, 1'b0, 2'd0, 1'b0, 32'h11, 32'd0, 1, 1, 32'h80FF_7F01,
              30'h4, 4'b0010, 32'd0, 32'h0000_007F, 1'b0);
    do_access("sb", 1'b0, 1'b1, 2'd0, 1'b0, 32'h21, 32'h1234_56AB, 0, 0, 32'd0,
              30'h8, 4'b0010, 32'hABAB_ABAB, 32'd0, 1'b0);
  endtask

  task automatic test_half();
    do_access("sh", 1'b0, 1'b1, 2'd1, 1'b0, 32'h06, 32'hAAAA_1234, 0, 0, 32'd0,
              30'h1, 4'b1100, 32'h1234_1234, 32'd0, 1'b0);
    do_access("lh", 1'b1, 1'b0, 2'd1, 1'b0, 32'h02, 32'd0, 0, 0, 32'h8001_0000,
              30'h0, 4'b1100, 32'd0, 32'hFFFF_8001, 1'b0);
    do_access("lhu", 1'b1, 1'b0, 2'd1, 1'b1, 32'h02, 32'd0, 0, 0, 32'h8001_0000,
              30'h0, 4'b1100, 32'd0, 32'h0000_8001, 1'b0);
    do_access("lh_low", 1'b1, 1'b0, 2'd1, 1'b0, 32'h30, 32'd0, 0, 0, 32'h8001_7FFE,
              30'hC, 4'b0011, 32'd0, 32'h0000_7FFE, 1'b0);
  endtask

  task automatic test_misaligned();
    @(negedge clk);
    MemReadM = 1'b1;
    MemSizeM = 2'd2;
    ALUOutM  = 32'h0A;
    #1;
    n_tests++;
    if (AlignErrM !== 1'b1 || StallM !== 1'b0 || dmem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_misaligned: got align=%b stall=%b valid=%b, required 1/0/0",
               AlignErrM, StallM, dmem_req_valid);
    end
    @(negedge clk);
    #1;
    n_tests++;
    if (dmem_req_valid !== 1'b0 || StallM !== 1'b0) begin
      n_fail++;
      $display("FAIL lw_misaligned_idle: got valid=%b stall=%b, required 0/0", dmem_req_valid, StallM);
    end
    MemSizeM = 2'd1;
    ALUOutM  = 32'h05;
    #1;
    n_tests++;
    if (AlignErrM !== 1'b1 || StallM !== 1'b0) begin
      n_fail++;
      $display("FAIL lh_misaligned: got align=%b stall=%b, required 1/0", AlignErrM, StallM);
    end
    clear_inputs();
    #1;
    n_tests++;
    if (AlignErrM !== 1'b0) begin
      n_fail++;
      $display("FAIL align_clear: got %b, required 0", AlignErrM);
    end
  endtask

  task automatic test_timeout();
    do_access("lw_timeout", 1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0, 5, -1, 32'd0,
              30'h10, 4'b1111, 32'd0, 32'd0, 1'b1);
  endtask

  task automatic test_back_to_back();
    do_access("lw_a", 1'b1, 1'b0, 2'd2, 1'b0, 32'h0C, 32'd0, 0, 0, 32'h1234_5678,
              30'h3, 4'b1111, 32'd0, 32'h1234_5678, 1'b0);
    do_access("lw_b", 1'b1, 1'b0, 2'd3, 1'b0, 32'h100, 32'd0, 2, 3, 32'hCAFE_F00D,
              30'h40, 4'b1111, 32'd0, 32'hCAFE_F00D, 1'b0);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    MemReadM = 1'b1;
    MemSizeM = 2'd2;
    ALUOutM  = 32'h20;
    @(negedge clk);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    #1;
    n_tests++;
    if (StallM !== 1'b1 || dmem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_wait: got stall=%b valid=%b, required 1/0", StallM, dmem_req_valid);
    end
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (StallM !== 1'b0 || dmem_req_valid !== 1'b0 || BusErrM !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_idle: got stall=%b valid=%b bus=%b, required 0/0/0",
               StallM, dmem_req_valid, BusErrM);
    end
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = 32'hBAD0_BAD0;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    #1;
    n_tests++;
    if (StallM !== 1'b0 || LoadDataM !== 32'd0 || dmem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_late_rsp: got stall=%b load=%h valid=%b, required 0/0/0",
               StallM, LoadDataM, dmem_req_valid);
    end
    do_access("lw_after_rst", 1'b1, 1'b0, 2'd2, 1'b0, 32'h24, 32'd0, 0, 0, 32'h0BAD_F00D,
              30'h9, 4'b1111, 32'd0, 32'h0BAD_F00D, 1'b0);
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_byte();
    test_half();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
